// File: rtl/receptor_ps2_verificado.sv
// PS/2 device-to-host receiver with clock deglitching, parity/stop checking
// and an inter-bit watchdog. Only verified frames reach dout.
// Ports:
//   clk          system clock, all logic on posedge
//   reset        asynchronous active-low reset
//   ps2data      raw PS/2 data line (asynchronous)
//   ps2clk       raw PS/2 clock line (asynchronous)
//   rx_en        allows a new frame to start
//   rx_done_tick one-cycle pulse, dout just loaded with a verified frame
//   parity_err   one-cycle pulse, frame had bad parity
//   frame_err    one-cycle pulse, bad stop bit or inter-bit timeout
//   dout         last verified frame {stop, parity, data[7:0], start}
module receptor_ps2_verificado #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2data,
  input  logic        ps2clk,
  input  logic        rx_en,
  output logic        rx_done_tick,
  output logic        parity_err,
  output logic        frame_err,
  output logic [10:0] dout
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t                state;
  logic                  ps2clk_s1, ps2clk_s;
  logic                  ps2data_s1, ps2data_s;
  logic [FILTER_LEN-1:0] hist;
  logic [FILTER_LEN-1:0] hist_nxt;
  logic                  filt_clk, filt_clk_d;
  logic                  fall;
  logic [10:0]           sreg;
  logic [3:0]            n;
  logic [WD_W-1:0]       wd;

  assign hist_nxt = {hist[FILTER_LEN-2:0], ps2clk_s};
  assign fall     = filt_clk_d & ~filt_clk;

  // Two-flop synchronisers and ps2clk glitch filter. The filtered clock is
  // decided from the history including the sample being shifted in, so it
  // changes FILTER_LEN cycles after the synced clock settles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps2clk_s1  <= 1'b1;
      ps2clk_s   <= 1'b1;
      ps2data_s1 <= 1'b1;
      ps2data_s  <= 1'b1;
      hist       <= '1;
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
    end else begin
      ps2clk_s1  <= ps2clk;
      ps2clk_s   <= ps2clk_s1;
      ps2data_s1 <= ps2data;
      ps2data_s  <= ps2data_s1;
      hist       <= hist_nxt;
      if (&hist_nxt)
        filt_clk <= 1'b1;
      else if (~|hist_nxt)
        filt_clk <= 1'b0;
      filt_clk_d <= filt_clk;
    end
  end

  // Frame FSM: start detect, bit shifting with watchdog, final check.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      sreg         <= '0;
      n            <= '0;
      wd           <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (fall && rx_en && !ps2data_s) begin
            sreg  <= {ps2data_s, sreg[10:1]};
            n     <= 4'd9;
            wd    <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (fall) begin
            sreg <= {ps2data_s, sreg[10:1]};
            wd   <= '0;
            if (n == 4'd0)
              state <= CHECK;
            else
              n <= n - 4'd1;
          end else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
            // Stalled frame: abort, watchdog holds at the abort value.
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        CHECK: begin
          // Stop bit outranks parity; at most one tick per frame.
          if (!sreg[10])
            frame_err <= 1'b1;
          else if (!(^sreg[9:1]))
            parity_err <= 1'b1;
          else begin
            dout         <= sreg;
            rx_done_tick <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_receptor_ps2_verificado.sv
// Bench for receptor_ps2_verificado. PS/2 timing is scaled down (half period
// of H clk cycles) and the watchdog is shortened so the run stays small.
module tb_receptor_ps2_verificado;

  localparam int L = 8;
  localparam int T = 300;
  localparam int H = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ps2data = 1'b1;
  logic        ps2clk = 1'b1;
  logic        rx_en = 1'b1;
  logic        rx_done_tick, parity_err, frame_err;
  logic [10:0] dout;

  receptor_ps2_verificado #(.FILTER_LEN(L), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset(reset), .ps2data(ps2data), .ps2clk(ps2clk),
    .rx_en(rx_en), .rx_done_tick(rx_done_tick), .parity_err(parity_err),
    .frame_err(frame_err), .dout(dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errors = 0;

  // Model state: last published frame and the one pending outcome.
  logic [10:0] model_dout = '0;
  int          sched_cyc = -1;
  int          sched_kind = 0;  // 1 done, 2 parity, 3 frame
  logic [10:0] sched_dout = '0;
  int          done_cnt = 0, perr_cnt = 0, ferr_cnt = 0;

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic ed, ep, ef;
    ed = (cyc == sched_cyc) && (sched_kind == 1);
    ep = (cyc == sched_cyc) && (sched_kind == 2);
    ef = (cyc == sched_cyc) && (sched_kind == 3);
    if (ed) model_dout = sched_dout;
    vectors++;
    if (rx_done_tick !== ed || parity_err !== ep || frame_err !== ef ||
        dout !== model_dout) begin
      errors++;
      $display("FAIL cycle %0d outputs: got done=%b perr=%b ferr=%b dout=%h, want done=%b perr=%b ferr=%b dout=%h",
               cyc, rx_done_tick, parity_err, frame_err, dout, ed, ep, ef, model_dout);
    end
    done_cnt += int'(rx_done_tick);
    perr_cnt += int'(parity_err);
    ferr_cnt += int'(frame_err);
  end

  task automatic wait_cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  // Outcome of a complete frame from its fields.
  function automatic int classify(input logic [7:0] d, input logic p, input logic s);
    if (!s) return 3;
    if ((($countones(d) + int'(p)) % 2) == 0) return 2;
    return 1;
  endfunction

  // mode 0: no outcome expected, 1: complete frame, 2: stalls after nbits.
  task automatic frame(input logic [7:0] d, input logic p, input logic s,
                       input int nbits, input int glitch_bit,
                       input int rxoff_after, input int mode);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (i == glitch_bit) begin
        wait_cyc(4);
        ps2clk = 1'b0;
        wait_cyc(L - 2);
        ps2clk = 1'b1;
        wait_cyc(H / 2 - 4 - (L - 2));
      end else begin
        wait_cyc(H / 2);
      end
      ps2data = f[i];
      wait_cyc(H / 2);
      ps2clk = 1'b0;
      if (i == nbits - 1) begin
        if (mode == 1) begin
          sched_kind = classify(d, p, s);
          sched_dout = f;
          sched_cyc  = cyc + 4 + L;
        end else if (mode == 2) begin
          sched_kind = 3;
          sched_cyc  = cyc + 3 + L + T;
        end
      end
      wait_cyc(H);
      ps2clk = 1'b1;
      if (i == rxoff_after) rx_en = 1'b0;
    end
  endtask

  initial begin
    wait_cyc(3);
    chk("reset dout", int'(dout), 0);
    reset = 1'b1;
    wait_cyc(20);

    // Good frame 0x1C
    frame(8'h1C, odd_par(8'h1C), 1'b1, 11, -1, -1, 1);
    wait_cyc(30);
    chk("t1 dout", int'(dout), 'h438);
    chk("t1 done count", done_cnt, 1);
    chk("t1 error counts", perr_cnt + ferr_cnt, 0);

    // Bad parity, then bad stop bit
    frame(8'h1C, 1'b1, 1'b1, 11, -1, -1, 1);
    wait_cyc(30);
    chk("t2 parity count", perr_cnt, 1);
    chk("t2 dout held", int'(dout), 'h438);
    frame(8'h1C, 1'b0, 1'b0, 11, -1, -1, 1);
    wait_cyc(30);
    chk("t2 frame count", ferr_cnt, 1);
    chk("t2 parity count after stop err", perr_cnt, 1);
    chk("t2 done count", done_cnt, 1);

    // Glitches in IDLE and mid-frame
    ps2clk = 1'b0;
    wait_cyc(L - 2);
    ps2clk = 1'b1;
    wait_cyc(30);
    frame(8'hF0, odd_par(8'hF0), 1'b1, 11, 4, -1, 1);
    wait_cyc(30);
    chk("t3 dout", int'(dout), 'h7E0);
    chk("t3 done count", done_cnt, 2);

    // Stall after 5 bits
    frame(8'h1C, 1'b0, 1'b1, 5, -1, -1, 2);
    wait_cyc(T + 20);
    chk("t4 frame count", ferr_cnt, 2);
    frame(8'h1C, odd_par(8'h1C), 1'b1, 11, -1, -1, 1);
    wait_cyc(30);
    chk("t4 dout", int'(dout), 'h438);
    chk("t4 done count", done_cnt, 3);

    // rx_en gating
    rx_en = 1'b0;
    frame(8'h1C, odd_par(8'h1C), 1'b1, 11, -1, -1, 0);
    wait_cyc(T + 20);
    chk("t5 ticks while disabled", done_cnt + perr_cnt + ferr_cnt, 6);
    rx_en = 1'b1;
    wait_cyc(10);
    frame(8'hF0, odd_par(8'hF0), 1'b1, 11, -1, 3, 1);
    rx_en = 1'b1;
    wait_cyc(30);
    chk("t5 dout", int'(dout), 'h7E0);
    chk("t5 done count", done_cnt, 4);

    // Reset mid-frame
    frame(8'h1C, odd_par(8'h1C), 1'b1, 7, -1, -1, 0);
    reset = 1'b0;
    model_dout = '0;
    sched_cyc = -1;
    wait_cyc(5);
    chk("t6 dout in reset", int'(dout), 0);
    reset = 1'b1;
    wait_cyc(20);
    frame(8'hF0, odd_par(8'hF0), 1'b1, 11, -1, -1, 1);
    wait_cyc(T + 20);
    chk("t6 dout", int'(dout), 'h7E0);
    chk("t6 done count", done_cnt, 5);
    chk("t6 error counts", perr_cnt + ferr_cnt, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
